// File: rtl/next_pc_unit.sv
// next_pc_unit
// Fetch-control stage of the single-cycle LEGv8 datapath. Owns the program
// counter and picks the next fetch address on every cycle:
// - PC+4 for sequential flow.
// - The CBZ target when Branch is set and the ALU reports Zero.
// - The B target when UncondBranch is set. B wins if both controls are set.
// It also supports stalls, detects the HLT #0 word, and counts retired
// instructions with a counter that saturates instead of wrapping.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   synchronous active-high reset (beats every other input)
//   Stall        in   hold PC, counters and state for this cycle
//   InstOut[31:0] in  current instruction word
//   Branch       in   conditional branch (CBZ) control
//   UncondBranch in   unconditional branch (B) control
//   Zero         in   ALU zero flag
//   PCIn[63:0]   out  registered current PC
//   count        out  retired-instruction count, saturating
//   Taken        out  combinational: current instruction redirects the PC
//   Halted       out  registered: fetch has stopped on HLT
//
// Optional feature (macro BRANCH_STATS_EN). When defined, two more saturating
// outputs are added:
//   TakenCount   counts redirected fetches.
//   BranchCount  counts branch instructions, taken or not.
// Both outputs are sized COUNT_W.

module next_pc_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] HALT_WORD = 32'hD4400000,
  parameter int          COUNT_W   = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Stall,
  input  logic [31:0]        InstOut,
  input  logic               Branch,
  input  logic               UncondBranch,
  input  logic               Zero,
  output logic [63:0]        PCIn,
  output logic [COUNT_W-1:0] count,
  output logic               Taken,
  output logic               Halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [COUNT_W-1:0] TakenCount,
  output logic [COUNT_W-1:0] BranchCount
`endif
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]         r_state;
  logic [63:0]        r_pc;
  logic [COUNT_W-1:0] r_count;

  logic        w_run;
  logic        w_cond_taken;
  logic        w_taken;
  logic        w_advance;
  logic        w_is_halt;
  logic [63:0] w_b_off;
  logic [63:0] w_cb_off;
  logic [63:0] w_next_pc;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  assign w_run        = (r_state == S_RUN);
  assign w_cond_taken = Branch & Zero;
  assign w_taken      = w_run & (UncondBranch | w_cond_taken);
  // A retire slot exists only in RUN with no stall.
  assign w_advance    = w_run & ~Stall;
  assign w_is_halt    = (InstOut == HALT_WORD);

  // Word offsets sign-extended to 64 bits, then scaled to bytes.
  assign w_b_off  = {{36{InstOut[25]}}, InstOut[25:0], 2'b00};
  assign w_cb_off = {{43{InstOut[23]}}, InstOut[23:5], 2'b00};

  // UncondBranch is tested first, so it takes priority over CBZ.
  always_comb begin
    w_next_pc = r_pc + 64'd4;
    if (UncondBranch)
      w_next_pc = r_pc + w_b_off;
    else if (w_cond_taken)
      w_next_pc = r_pc + w_cb_off;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_count <= '0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN: begin
          if (!Stall) begin
            r_count <= sat_inc(r_count);
            // HLT retires but leaves the PC sitting on its own address.
            if (w_is_halt)
              r_state <= S_HALT;
            else
              r_pc <= w_next_pc;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_BOOT;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [COUNT_W-1:0] r_taken_count;
  logic [COUNT_W-1:0] r_branch_count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_taken_count  <= '0;
      r_branch_count <= '0;
    end else if (w_advance) begin
      if (w_taken)
        r_taken_count <= sat_inc(r_taken_count);
      if (Branch | UncondBranch)
        r_branch_count <= sat_inc(r_branch_count);
    end
  end

  assign TakenCount  = r_taken_count;
  assign BranchCount = r_branch_count;
`endif

  assign PCIn   = r_pc;
  assign count  = r_count;
  assign Taken  = w_taken;
  assign Halted = (r_state == S_HALT);

endmodule
